// File: rtl/button_event_ctrl.sv
// button_event_ctrl: turns debounced levels into PRESS/RELEASE/LONG events, one pending slot per type
// per channel, and round-robin arbitrates them onto a single valid/ready event port.
module button_event_ctrl #(
    parameter int NUM_CH     = 4,
    parameter int TICK_DIV   = 1000,
    parameter int LONG_TICKS = 500,
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock,
    input  logic              i_nrst,
    input  logic [NUM_CH-1:0] i_db,
    input  logic              i_evt_ready,
    input  logic              i_ovr_clr,
    output logic              o_evt_valid,
    output logic [CW-1:0]     o_evt_ch,
    output logic [1:0]        o_evt_code,
    output logic [NUM_CH-1:0] o_overrun
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int HW = $clog2(LONG_TICKS);

    typedef enum logic [1:0] {IDLE, PRESSED, HELD} state_t;

    state_t            r_st   [NUM_CH];
    logic [HW-1:0]     r_hold [NUM_CH];
    logic [PW-1:0]     r_pre;
    logic [NUM_CH-1:0] r_pend_p, r_pend_r, r_pend_l;
    logic [CW-1:0]     r_rr;
    logic              w_tick, w_load, w_found;
    logic [NUM_CH-1:0] w_set_p, w_set_r, w_set_l, w_clr_p, w_clr_r, w_clr_l, w_any, w_sel_oh;
    logic [CW-1:0]     w_sel, w_idx;
    logic [1:0]        w_code;

    assign w_tick = r_pre == PW'(TICK_DIV - 1);

    // Release is checked before the tick, so a release on the LONG tick yields only RELEASE.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            w_set_p[c] = r_st[c] == IDLE && i_db[c];
            w_set_r[c] = r_st[c] != IDLE && !i_db[c];
            w_set_l[c] = r_st[c] == PRESSED && i_db[c] && w_tick && r_hold[c] == HW'(LONG_TICKS - 1);
        end
    end

    assign w_any = r_pend_p | r_pend_r | r_pend_l;

    // Walk the search order backwards so the last hit is the first channel after the RR pointer.
    always_comb begin
        w_sel   = '0;
        w_idx   = '0;
        w_found = 1'b0;
        for (int k = NUM_CH; k >= 1; k--) begin
            w_idx = CW'((int'(r_rr) + k) % NUM_CH);
            if (w_any[w_idx]) begin
                w_sel   = w_idx;
                w_found = 1'b1;
            end
        end
    end

    assign w_code   = r_pend_p[w_sel] ? 2'b00 : r_pend_l[w_sel] ? 2'b10 : 2'b01;
    assign w_load   = !o_evt_valid || i_evt_ready;
    assign w_sel_oh = (w_load && w_found) ? NUM_CH'(1) << w_sel : '0;
    assign w_clr_p  = w_code == 2'b00 ? w_sel_oh : '0;
    assign w_clr_r  = w_code == 2'b01 ? w_sel_oh : '0;
    assign w_clr_l  = w_code == 2'b10 ? w_sel_oh : '0;

    always_ff @(posedge clock or negedge i_nrst) begin
        if (!i_nrst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_st[c]   <= IDLE;
                r_hold[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                case (r_st[c])
                    IDLE: if (i_db[c]) begin
                        r_st[c]   <= PRESSED;
                        r_hold[c] <= '0;
                    end
                    PRESSED: if (!i_db[c]) r_st[c] <= IDLE;
                        else if (w_tick) begin
                            if (w_set_l[c]) r_st[c] <= HELD;
                            else r_hold[c] <= r_hold[c] + 1'b1;
                        end
                    HELD: if (!i_db[c]) r_st[c] <= IDLE;
                    default: r_st[c] <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clock or negedge i_nrst) begin
        if (!i_nrst) begin
            r_pre       <= '0;
            r_pend_p    <= '0;
            r_pend_r    <= '0;
            r_pend_l    <= '0;
            r_rr        <= '0;
            o_evt_valid <= 1'b0;
            o_evt_ch    <= '0;
            o_evt_code  <= '0;
            o_overrun   <= '0;
        end else begin
            r_pre     <= w_tick ? '0 : r_pre + 1'b1;
            r_pend_p  <= (r_pend_p & ~w_clr_p) | w_set_p;
            r_pend_r  <= (r_pend_r & ~w_clr_r) | w_set_r;
            r_pend_l  <= (r_pend_l & ~w_clr_l) | w_set_l;
            o_overrun <= (i_ovr_clr ? '0 : o_overrun)
                       | (w_set_p & r_pend_p & ~w_clr_p)
                       | (w_set_r & r_pend_r & ~w_clr_r)
                       | (w_set_l & r_pend_l & ~w_clr_l);
            if (w_load) begin
                o_evt_valid <= w_found;
                if (w_found) begin
                    o_evt_ch   <= w_sel;
                    o_evt_code <= w_code;
                    r_rr       <= w_sel;
                end
            end
        end
    end
endmodule
